conv3x3_frame_sequencer: RTL and testbench

Sequences one serial 3x3 convolution engine across a full IMG_H x IMG_W input feature map. Uses valid convolution, with no padding.

---
 rtl/conv3x3_frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_conv3x3_frame_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_frame_sequencer.sv
// Walks a 3x3 window over an IMG_H x IMG_W feature map (valid convolution), feeds one serial
// conv engine and streams results out in raster order. Optional macro SEQ_RELU_EN clamps negative results to 0.
`timescale 1ns/1ps
module conv3x3_frame_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic [9*DATA_WIDTH-1:0] win_flat,
    output logic                    conv_start,
    input  logic                    conv_done,
    input  logic [ACC_WIDTH-1:0]    conv_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    out_data,
    output logic [ADDR_WIDTH-1:0]   out_row,
    output logic [ADDR_WIDTH-1:0]   out_col
);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, KICK, WAIT, OUT, FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] W_A     = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] COL_END = ADDR_WIDTH'(IMG_W - 3);
    localparam logic [ADDR_WIDTH-1:0] ROW_END = ADDR_WIDTH'(IMG_H - 3);

    state_t                       state;
    logic [3:0]                   idx;
    logic [3:0]                   rd_idx;
    logic                         rd_valid;
    logic [ADDR_WIDTH-1:0]        row;
    logic [ADDR_WIDTH-1:0]        col;
    logic [8:0][DATA_WIDTH-1:0]   win;

    assign win_flat = win;

    // Address of window element k (k = dr*3+dc) for the output at (r, c); wraps at ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [ADDR_WIDTH-1:0] r,
                                                       input logic [ADDR_WIDTH-1:0] c,
                                                       input logic [3:0]            k);
        logic [1:0] dr;
        logic [1:0] dc;
        case (k)
            4'd0, 4'd1, 4'd2: dr = 2'd0;
            4'd3, 4'd4, 4'd5: dr = 2'd1;
            default:          dr = 2'd2;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: dc = 2'd0;
            4'd1, 4'd4, 4'd7: dc = 2'd1;
            default:          dc = 2'd2;
        endcase
        return (r + ADDR_WIDTH'(dr)) * W_A + c + ADDR_WIDTH'(dc);
    endfunction

    // NOTE: all state below is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            rd_idx      <= '0;
            rd_valid    <= 1'b0;
            row         <= '0;
            col         <= '0;
            // NOTE: the window is only nine registers and is visible on a port, so it is
            // reset along with everything else instead of being left as uninitialised storage.
            win         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            conv_start  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_row     <= '0;
            out_col     <= '0;
        end else begin
            // Read data lags the strobe by one cycle, so its window slot lags idx by one.
            rd_valid   <= mem_rd_en;
            rd_idx     <= idx;
            if (rd_valid) win[rd_idx] <= mem_rd_data;
            done       <= 1'b0;
            conv_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        row       <= '0;
                        col       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= pix_addr('0, '0, 4'd0);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (idx == 4'd8) begin
                        mem_rd_en <= 1'b0;
                        state     <= LAST;
                    end else begin
                        idx      <= idx + 4'd1;
                        mem_addr <= pix_addr(row, col, idx + 4'd1);
                    end
                end
                LAST: begin
                    conv_start <= 1'b1;
                    state      <= KICK;
                end
                KICK: state <= WAIT;
                WAIT: begin
                    if (conv_done) begin
`ifdef SEQ_RELU_EN
                        out_data <= conv_result[ACC_WIDTH-1] ? '0 : conv_result;
`else
                        out_data <= conv_result;
`endif
                        out_row   <= row;
                        out_col   <= col;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (col < COL_END) begin
                            col       <= col + 1'b1;
                            idx       <= '0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= pix_addr(row, col + 1'b1, 4'd0);
                            state     <= FETCH;
                        end else if (row < ROW_END) begin
                            col       <= '0;
                            row       <= row + 1'b1;
                            idx       <= '0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= pix_addr(row + 1'b1, '0, 4'd0);
                            state     <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_frame_sequencer.sv
// Directed bench for conv3x3_frame_sequencer: a 4x4 and a 3x3 instance, each with its own
// synchronous feature memory and a fixed-latency behavioural conv engine.
`timescale 1ns/1ps
module tb_conv3x3_frame_sequencer;

    typedef struct {
        int     row;
        int     col;
        longint data;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int weight = 1;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance a: 4x4 map ----------------
    logic               a_start = 1'b0, a_busy, a_done, a_mem_rd_en, a_conv_start;
    logic               a_conv_done = 1'b0, a_out_valid, a_out_ready = 1'b1;
    logic [15:0]        a_mem_addr, a_out_row, a_out_col;
    logic [7:0]         a_mem_rd_data = '0;
    logic [71:0]        a_win_flat;
    logic [31:0]        a_conv_result = '0;
    logic signed [31:0] a_out_data;

    conv3x3_frame_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .IMG_W(4), .IMG_H(4), .ADDR_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr), .mem_rd_data(a_mem_rd_data),
        .win_flat(a_win_flat), .conv_start(a_conv_start), .conv_done(a_conv_done),
        .conv_result(a_conv_result), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_row(a_out_row), .out_col(a_out_col)
    );

    // ---------------- instance b: 3x3 map ----------------
    logic               b_start = 1'b0, b_busy, b_done, b_mem_rd_en, b_conv_start;
    logic               b_conv_done = 1'b0, b_out_valid, b_out_ready = 1'b1;
    logic [15:0]        b_mem_addr, b_out_row, b_out_col;
    logic [7:0]         b_mem_rd_data = '0;
    logic [71:0]        b_win_flat;
    logic [31:0]        b_conv_result = '0;
    logic signed [31:0] b_out_data;

    conv3x3_frame_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .IMG_W(3), .IMG_H(3), .ADDR_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rd_data(b_mem_rd_data),
        .win_flat(b_win_flat), .conv_start(b_conv_start), .conv_done(b_conv_done),
        .conv_result(b_conv_result), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_row(b_out_row), .out_col(b_out_col)
    );

    // ---------------- memories and engines ----------------
    logic [7:0] mem_a [0:15];
    logic [7:0] mem_b [0:15];

    always @(posedge clk) if (a_mem_rd_en) a_mem_rd_data <= mem_a[a_mem_addr[3:0]];
    always @(posedge clk) if (b_mem_rd_en) b_mem_rd_data <= mem_b[b_mem_addr[3:0]];

    function automatic logic [31:0] dot(input logic [71:0] w, input int wt);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'($signed(w[k*8 +: 8])) * wt;
        return 32'(s);
    endfunction

    int a_cnt = 0;
    int b_cnt = 0;
    always @(posedge clk) begin
        a_conv_done <= 1'b0;
        if (a_conv_start) a_cnt <= 3;
        else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) begin
                a_conv_done   <= 1'b1;
                a_conv_result <= dot(a_win_flat, weight);
            end
        end
    end
    always @(posedge clk) begin
        b_conv_done <= 1'b0;
        if (b_conv_start) b_cnt <= 3;
        else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) begin
                b_conv_done   <= 1'b1;
                b_conv_result <= dot(b_win_flat, weight);
            end
        end
    end

    // ---------------- monitors (sample on the falling edge) ----------------
    out_t a_q[$];
    out_t b_q[$];
    int   b_addr_q[$];
    int   b_cyc_q[$];
    int   a_done_cnt = 0, a_done_hs = -1, a_stall_cycles = 0, a_viol = 0;
    int   b_done_cnt = 0;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_data = '0;
    logic [15:0] prev_row = '0, prev_col = '0;

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready)
            a_q.push_back('{int'(a_out_row), int'(a_out_col), longint'(a_out_data)});
        if (a_done) begin
            a_done_cnt++;
            a_done_hs = a_q.size();
        end
        if (a_out_valid && !a_out_ready) a_stall_cycles++;
        if (a_out_valid && a_mem_rd_en) a_viol++;
        if (prev_stalled && (!a_out_valid || a_out_data != prev_data ||
                             a_out_row != prev_row || a_out_col != prev_col)) a_viol++;
        prev_stalled = a_out_valid && !a_out_ready;
        prev_data    = a_out_data;
        prev_row     = a_out_row;
        prev_col     = a_out_col;
    end

    always @(negedge clk) begin
        if (b_mem_rd_en) begin
            b_addr_q.push_back(int'(b_mem_addr));
            b_cyc_q.push_back(cyc);
        end
        if (b_out_valid && b_out_ready)
            b_q.push_back('{int'(b_out_row), int'(b_out_col), longint'(b_out_data)});
        if (b_done) b_done_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on instance a; optionally stalls each output 5 cycles or re-pulses start in WAIT.
    task automatic run_a(input bit stall, input bit poke);
        bit seen;
        a_q.delete();
        a_done_cnt = 0;
        a_done_hs = -1;
        a_stall_cycles = 0;
        a_viol = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        if (poke) begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                tick();
                seen = a_conv_start;
            end
            chk("poke_kick_seen", seen, 1);
            tick();
            a_start = 1'b1;
            tick();
            a_start = 1'b0;
        end
        if (stall) begin
            a_out_ready = 1'b0;
            for (int n = 0; n < 4; n++) begin
                seen = 1'b0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    tick();
                    seen = a_out_valid;
                end
                if (!seen) chk($sformatf("stall_valid_timeout%0d", n), 0, 1);
                repeat (5) tick();
                a_out_ready = 1'b1;
                tick();
                a_out_ready = 1'b0;
            end
            a_out_ready = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            tick();
            seen = (a_done_cnt > 0);
        end
        chk("a_frame_done", seen, 1);
        repeat (3) tick();
    endtask

    task automatic check_a(input string pfx, input int e0, input int e1, input int e2, input int e3);
        int exp_v [4];
        exp_v = '{e0, e1, e2, e3};
        chk({pfx, "_count"}, a_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < a_q.size()) begin
                chk($sformatf("%s_row%0d", pfx, i), a_q[i].row, i / 2);
                chk($sformatf("%s_col%0d", pfx, i), a_q[i].col, i % 2);
                chk($sformatf("%s_data%0d", pfx, i), a_q[i].data, exp_v[i]);
            end
        end
        chk({pfx, "_done_cnt"}, a_done_cnt, 1);
        chk({pfx, "_done_after4"}, a_done_hs, 4);
        chk({pfx, "_busy_after"}, a_busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'(i + 1);
        end

        // Reset state
        repeat (3) tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rd_en", a_mem_rd_en, 0);
        chk("rst_addr", a_mem_addr, 0);
        chk("rst_win_nonzero", (a_win_flat !== 72'd0), 0);
        chk("rst_conv_start", a_conv_start, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Full 4x4 frame, weights 1, ready always high
        run_a(1'b0, 1'b0);
        check_a("f1", 45, 54, 81, 90);

        // Same frame with a 5-cycle stall on every output
        run_a(1'b1, 1'b0);
        check_a("f2", 45, 54, 81, 90);
        chk("f2_stall_cycles", a_stall_cycles, 20);
        chk("f2_hold_violations", a_viol, 0);

        // Negative weights
        weight = -1;
        run_a(1'b0, 1'b0);
`ifdef SEQ_RELU_EN
        check_a("f3", 0, 0, 0, 0);
`else
        check_a("f3", -45, -54, -81, -90);
`endif
        weight = 1;

        // Minimum 3x3 map on instance b
        b_q.delete();
        b_addr_q.delete();
        b_cyc_q.delete();
        b_done_cnt = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = (b_done_cnt > 0);
        end
        chk("b_frame_done", seen, 1);
        repeat (3) tick();
        chk("b_count", b_q.size(), 1);
        if (b_q.size() > 0) begin
            chk("b_row", b_q[0].row, 0);
            chk("b_col", b_q[0].col, 0);
            chk("b_data", b_q[0].data, 45);
        end
        chk("b_done_cnt", b_done_cnt, 1);
        chk("b_busy_after", b_busy, 0);
        chk("b_addr_count", b_addr_q.size(), 9);
        for (int k = 0; k < 9 && k < b_addr_q.size(); k++) begin
            chk($sformatf("b_addr%0d", k), b_addr_q[k], k);
            chk($sformatf("b_addr_cycle%0d", k), b_cyc_q[k] - b_cyc_q[0], k);
        end

        // start re-pulsed during WAIT is ignored
        run_a(1'b0, 1'b1);
        check_a("f5", 45, 54, 81, 90);

        // Asynchronous reset in the second output's fetch
        a_q.delete();
        a_done_cnt = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = (a_q.size() == 1) && a_mem_rd_en;
        end
        chk("rst_mid_fetch_reached", seen, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_rd_en", a_mem_rd_en, 0);
        chk("arst_addr", a_mem_addr, 0);
        chk("arst_win_nonzero", (a_win_flat !== 72'd0), 0);
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_out_data", a_out_data, 0);
        chk("arst_out_row", a_out_row, 0);
        chk("arst_out_col", a_out_col, 0);
        tick();
        tick();
        chk("arst_no_done", a_done_cnt, 0);
        rst_n = 1'b1;
        tick();
        run_a(1'b0, 1'b0);
        check_a("f6", 45, 54, 81, 90);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
